// File: rtl/sbox_iter_if.sv
// Word stream between the round-state register and the byte-substitution engine.
// slave is the engine side; master is the upstream/downstream side driving it.
interface sbox_iter_if #(
  parameter int NLANES = 4
);
  logic                valid_i;
  logic                ready_o;
  logic [8*NLANES-1:0] data_i;
  logic                inv_i;
  logic                valid_o;
  logic                ready_i;
  logic [8*NLANES-1:0] data_o;

  modport slave (
    input  valid_i, data_i, inv_i, ready_i,
    output ready_o, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, inv_i, ready_i,
    input  ready_o, valid_o, data_o
  );
endinterface

// File: rtl/sbox_iter.sv
// Iterative AES S-box engine: substitutes an NLANES-byte word NUNITS bytes per cycle,
// lowest bytes first, in a single working register that is also the output.
module sbox_iter #(
  parameter int NLANES = 4,
  parameter int NUNITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  sbox_iter_if.slave bus
);
  localparam int BEATS = (NUNITS > 0) ? NLANES / NUNITS : 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int UW    = 8 * NUNITS;
  localparam int DW    = 8 * NLANES;

  if (NUNITS < 1 || NUNITS > NLANES || (NLANES % NUNITS) != 0) begin : g_bad_nunits
    $error("sbox_iter: NUNITS must lie in 1..NLANES and divide NLANES");
  end
  if ($bits(bus.data_i) != DW) begin : g_bad_width
    $error("sbox_iter: interface NLANES does not match engine NLANES");
  end

  // Entry 0 sits in the leftmost byte of each table.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_inv, w_inv_next;
  logic [DW-1:0] r_data, w_data_next;

  logic [UW-1:0] w_beat_in;
  logic [UW-1:0] w_beat_out;
  int            w_base;

  assign w_base    = UW * int'(r_cnt);
  assign w_beat_in = UW'(r_data >> w_base);

  for (genvar gi = 0; gi < NUNITS; gi++) begin : g_unit
    logic [7:0] w_byte;
    assign w_byte                  = w_beat_in[8*gi +: 8];
    assign w_beat_out[8*gi +: 8]   = r_inv ? SBOX_INV[w_byte] : SBOX_FWD[w_byte];
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_inv_next   = r_inv;
    w_data_next  = r_data;
    case (r_state)
      IDLE: begin
        if (bus.valid_i) begin
          w_data_next  = bus.data_i;
          w_inv_next   = bus.inv_i;
          w_cnt_next   = '0;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        w_data_next[w_base +: UW] = w_beat_out;
        if (r_cnt == CW'(BEATS - 1)) begin
          w_cnt_next   = '0;
          w_state_next = DONE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_inv   <= w_inv_next;
      r_data  <= w_data_next;
    end
  end

  // Handshake outputs decode the state register only, so no input reaches an output combinationally.
  assign bus.ready_o = (r_state == IDLE);
  assign bus.valid_o = (r_state == DONE);
  assign bus.data_o  = r_data;
endmodule

// File: tb/tb_sbox_iter.sv
// Bench for sbox_iter: directed scenarios on the default build plus a sweep over four
// NLANES/NUNITS builds, checked against S-box tables derived from GF(2^8) arithmetic.
module tb_sbox_iter;
  logic clk;
  logic rst_n;

  localparam int LANES   [4] = '{4, 4, 4, 16};
  localparam int BEATS_T [4] = '{4, 2, 1, 4};

  logic         drv_valid [4];
  logic         drv_inv   [4];
  logic         drv_ready [4];
  logic [127:0] drv_data  [4];
  logic         mon_valid [4];
  logic         mon_ready [4];
  logic [127:0] mon_data  [4];

  logic [127:0] sb_q [4][$];
  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  sbox_iter_if #(.NLANES(4))  if0 ();
  sbox_iter_if #(.NLANES(4))  if1 ();
  sbox_iter_if #(.NLANES(4))  if2 ();
  sbox_iter_if #(.NLANES(16)) if3 ();

  sbox_iter #(.NLANES(4),  .NUNITS(1)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0.slave));
  sbox_iter #(.NLANES(4),  .NUNITS(2)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1.slave));
  sbox_iter #(.NLANES(4),  .NUNITS(4)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2.slave));
  sbox_iter #(.NLANES(16), .NUNITS(4)) dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(if3.slave));

  assign if0.valid_i = drv_valid[0];
  assign if0.inv_i   = drv_inv[0];
  assign if0.ready_i = drv_ready[0];
  assign if0.data_i  = drv_data[0][31:0];
  assign if1.valid_i = drv_valid[1];
  assign if1.inv_i   = drv_inv[1];
  assign if1.ready_i = drv_ready[1];
  assign if1.data_i  = drv_data[1][31:0];
  assign if2.valid_i = drv_valid[2];
  assign if2.inv_i   = drv_inv[2];
  assign if2.ready_i = drv_ready[2];
  assign if2.data_i  = drv_data[2][31:0];
  assign if3.valid_i = drv_valid[3];
  assign if3.inv_i   = drv_inv[3];
  assign if3.ready_i = drv_ready[3];
  assign if3.data_i  = drv_data[3];

  assign mon_valid[0] = if0.valid_o;
  assign mon_ready[0] = if0.ready_o;
  assign mon_data[0]  = 128'(if0.data_o);
  assign mon_valid[1] = if1.valid_o;
  assign mon_ready[1] = if1.ready_o;
  assign mon_data[1]  = 128'(if1.data_o);
  assign mon_valid[2] = if2.valid_o;
  assign mon_ready[2] = if2.ready_o;
  assign mon_data[2]  = 128'(if2.data_o);
  assign mon_valid[3] = if3.valid_o;
  assign mon_ready[3] = if3.ready_o;
  assign mon_data[3]  = if3.data_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] b, s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_word(input logic [127:0] w, input logic inv, input int nl);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < nl; k++)
      r[8*k +: 8] = inv ? inv_tab[w[8*k +: 8]] : fwd_tab[w[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sb_pop(input int d);
    if (sb_q[d].size() == 0) return 'x;
    return sb_q[d].pop_front();
  endfunction

  // Called at a sample point; returns at the sample point just after the accept edge.
  task automatic accept(input int d, input logic [127:0] w, input logic iv, input logic [127:0] e);
    int n;
    n = 0;
    drv_data[d] = w; drv_inv[d] = iv; drv_valid[d] = 1'b1;
    while (!mon_ready[d] && n < 100) begin @(posedge clk); #1; n++; end
    if (!mon_ready[d]) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: dut%0d got ready_o=0 expected 1", d);
    end else begin
      sb_q[d].push_back(e);
      $display("[%0t] dut%0d accept in=%h inv=%0d", $time, d, w, iv);
    end
    @(posedge clk); #1;
    drv_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (mon_valid[d]) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (mon_ready[d] !== 1'b1) begin n_err++; $display("FAIL reset_ready: dut%0d got %b expected 1", d, mon_ready[d]); end
      n_cmp++; if (mon_valid[d] !== 1'b0) begin n_err++; $display("FAIL reset_valid: dut%0d got %b expected 0", d, mon_valid[d]); end
      n_cmp++; if (mon_data[d] !== 128'h0) begin n_err++; $display("FAIL reset_data: dut%0d got %h expected 0", d, mon_data[d]); end
    end
  endtask

  task automatic test_forward();
    int lat; logic [127:0] e;
    drv_ready[0] = 1'b1;
    accept(0, 128'h005301FF, 1'b0, 128'h63ED7C16);
    wait_valid(0, lat);
    e = sb_pop(0);
    $display("[%0t] dut0 result out=%h lat=%0d", $time, mon_data[0], lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL fwd_latency: got %0d expected 4", lat); end
    n_cmp++; if (mon_data[0] !== e) begin n_err++; $display("FAIL fwd_data: got %h expected %h", mon_data[0], e); end
    @(posedge clk); #1;
    n_cmp++; if (mon_valid[0] !== 1'b0) begin n_err++; $display("FAIL fwd_valid_pulse: got %b expected 0", mon_valid[0]); end
    n_cmp++; if (mon_ready[0] !== 1'b1) begin n_err++; $display("FAIL fwd_ready_back: got %b expected 1", mon_ready[0]); end
  endtask

  task automatic test_inverse();
    int lat; logic [127:0] e;
    drv_ready[0] = 1'b1;
    accept(0, 128'h63ED7C16, 1'b1, 128'h005301FF);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      drv_inv[0]  = ~drv_inv[0];
      drv_data[0] = {96'h0, $urandom};
      if (mon_valid[0]) begin lat = c; break; end
    end
    e = sb_pop(0);
    $display("[%0t] dut0 result out=%h lat=%0d", $time, mon_data[0], lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL inv_latency: got %0d expected 4", lat); end
    n_cmp++; if (mon_data[0] !== e) begin n_err++; $display("FAIL inv_data: got %h expected %h", mon_data[0], e); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic [127:0] e, held;
    drv_ready[0] = 1'b0;
    accept(0, 128'h12345678, 1'b0, model_word(128'h12345678, 1'b0, 4));
    wait_valid(0, lat);
    held = mon_data[0];
    drv_valid[0] = 1'b1; drv_data[0] = 128'hFFFFFFFF; drv_inv[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (mon_valid[0] !== 1'b1) begin n_err++; $display("FAIL bp_valid: cycle %0d got %b expected 1", c, mon_valid[0]); end
      n_cmp++; if (mon_data[0] !== held) begin n_err++; $display("FAIL bp_stable: cycle %0d got %h expected %h", c, mon_data[0], held); end
      n_cmp++; if (mon_ready[0] !== 1'b0) begin n_err++; $display("FAIL bp_ready: cycle %0d got %b expected 0", c, mon_ready[0]); end
      @(posedge clk); #1;
    end
    drv_ready[0] = 1'b1;
    e = sb_pop(0);
    $display("[%0t] dut0 result out=%h lat=%0d", $time, mon_data[0], lat);
    n_cmp++; if (mon_data[0] !== e) begin n_err++; $display("FAIL bp_data: got %h expected %h", mon_data[0], e); end
    @(posedge clk); #1;
    n_cmp++; if (mon_ready[0] !== 1'b1) begin n_err++; $display("FAIL bp_idle: got ready_o=%b expected 1", mon_ready[0]); end
    sb_q[0].push_back(128'h16161616);
    $display("[%0t] dut0 accept in=%h inv=0", $time, drv_data[0]);
    @(posedge clk); #1;
    drv_valid[0] = 1'b0;
    wait_valid(0, lat);
    e = sb_pop(0);
    $display("[%0t] dut0 result out=%h lat=%0d", $time, mon_data[0], lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL bp_new_latency: got %0d expected 4", lat); end
    n_cmp++; if (mon_data[0] !== e) begin n_err++; $display("FAIL bp_new_data: got %h expected %h", mon_data[0], e); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [127:0] e;
    drv_ready[0] = 1'b1;
    accept(0, 128'h0, 1'b0, 128'h63636363);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (mon_valid[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", mon_valid[0]); end
    n_cmp++; if (mon_data[0] !== 128'h0) begin n_err++; $display("FAIL rstmid_data: got %h expected 0", mon_data[0]); end
    n_cmp++; if (mon_ready[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b expected 1", mon_ready[0]); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) sb_q[d].delete();
    $display("[%0t] dut0 in-flight word discarded by reset", $time);
    @(posedge clk); #1;
    n_cmp++; if (mon_valid[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_no_partial: got valid_o=%b expected 0", mon_valid[0]); end
    accept(0, 128'h0, 1'b0, 128'h63636363);
    wait_valid(0, lat);
    e = sb_pop(0);
    $display("[%0t] dut0 result out=%h lat=%0d", $time, mon_data[0], lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL rstmid_latency: got %0d expected 4", lat); end
    n_cmp++; if (mon_data[0] !== e) begin n_err++; $display("FAIL rstmid_data_after: got %h expected %h", mon_data[0], e); end
    @(posedge clk); #1;
  endtask

  task automatic test_param_sweep();
    int lat [4];
    logic [127:0] w, e;
    logic [7:0] x;
    for (int d = 0; d < 4; d++) drv_ready[d] = 1'b1;
    for (int dir = 0; dir < 2; dir++) begin
      for (int base = 0; base < 256; base++) begin
        for (int d = 0; d < 4; d++) begin
          w = '0; e = '0;
          for (int k = 0; k < LANES[d]; k++) begin
            x = 8'(base + k);
            if (dir == 0) begin w[8*k +: 8] = x; e[8*k +: 8] = fwd_tab[x]; end
            else begin w[8*k +: 8] = fwd_tab[x]; e[8*k +: 8] = x; end
          end
          n_cmp++; if (mon_ready[d] !== 1'b1) begin n_err++; $display("FAIL sweep_ready: dut%0d got %b expected 1", d, mon_ready[d]); end
          drv_data[d] = w; drv_inv[d] = (dir == 1); drv_valid[d] = 1'b1;
          sb_q[d].push_back(e);
          lat[d] = -1;
        end
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) drv_valid[d] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
          @(posedge clk); #1;
          for (int d = 0; d < 4; d++) begin
            if (mon_valid[d] && lat[d] < 0) begin
              lat[d] = c;
              e = sb_pop(d);
              n_cmp++; if (mon_data[d] !== e) begin n_err++; $display("FAIL sweep_data: dut%0d inv=%0d base=%0d got %h expected %h", d, dir, base, mon_data[d], e); end
            end
          end
        end
        for (int d = 0; d < 4; d++) begin
          n_cmp++; if (lat[d] !== BEATS_T[d]) begin n_err++; $display("FAIL sweep_latency: dut%0d got %0d expected %0d", d, lat[d], BEATS_T[d]); end
          if (lat[d] < 0) e = sb_pop(d);
        end
        $display("[%0t] sweep inv=%0d base=%02h lat=%0d/%0d/%0d/%0d", $time, dir, base, lat[0], lat[1], lat[2], lat[3]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int got, last_acc, gap, wait_cnt, budget;
    logic [31:0] w;
    logic iv;
    logic [127:0] e;
    got = 0; last_acc = -1; budget = 0;
    drv_ready[0] = 1'b0;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          gap = $urandom_range(0, 2);
          w   = $urandom;
          iv  = 1'($urandom_range(0, 1));
          drv_valid[0] = 1'b0;
          repeat (gap) begin @(posedge clk); #1; end
          drv_valid[0] = 1'b1; drv_data[0] = {96'h0, w}; drv_inv[0] = iv;
          wait_cnt = 0;
          while (!mon_ready[0] && wait_cnt < 200) begin @(posedge clk); #1; wait_cnt++; end
          if (mon_ready[0]) begin
            sb_q[0].push_back(model_word({96'h0, w}, iv, 4));
            $display("[%0t] dut0 accept #%0d in=%h inv=%0d", $time, n, w, iv);
            if (last_acc >= 0) begin
              n_cmp++; if (cyc - last_acc < 6) begin n_err++; $display("FAIL stream_period: got %0d cycles expected at least 6", cyc - last_acc); end
            end
            last_acc = cyc;
          end else begin
            n_cmp++; n_err++;
            $display("FAIL stream_accept_timeout: word %0d got ready_o=0 expected 1", n);
          end
          @(posedge clk); #1;
        end
        drv_valid[0] = 1'b0;
      end
      begin
        while (got < 100 && budget < 5000) begin
          drv_ready[0] = ($urandom_range(0, 3) != 0);
          if (mon_valid[0] && drv_ready[0]) begin
            e = sb_pop(0);
            $display("[%0t] dut0 result #%0d out=%h", $time, got, mon_data[0]);
            n_cmp++; if (mon_data[0] !== e) begin n_err++; $display("FAIL stream_data: word %0d got %h expected %h", got, mon_data[0], e); end
            got++;
          end
          @(posedge clk); #1;
          budget++;
        end
        drv_ready[0] = 1'b1;
      end
    join
    n_cmp++; if (got !== 100) begin n_err++; $display("FAIL stream_count: got %0d expected 100", got); end
    for (int c = 0; c < 20; c++) begin
      if (mon_valid[0]) begin
        n_cmp++; n_err++;
        $display("FAIL stream_duplicate: got valid_o=1 expected 0 at %0t", $time);
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (sb_q[0].size() !== 0) begin n_err++; $display("FAIL stream_leftover: got %0d queued expected 0", sb_q[0].size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      drv_valid[d] = 1'b0; drv_inv[d] = 1'b0; drv_ready[d] = 1'b1; drv_data[d] = '0;
    end
    build_tables();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_forward();
    test_inverse();
    test_backpressure();
    test_reset_mid();
    test_param_sweep();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sbox_iter.md
# sbox_iter

Iterative, parametrised AES byte-substitution engine: takes an NLANES-byte word over a valid/ready handshake and applies the forward or inverse AES S-box to every byte. Bytes are processed NUNITS at a time over several cycles, so area and latency can be traded per instance. It is the sequential successor to the combinational `sbox`. It sits between the round-state register and the shift/mix stage of the cipher datapath.

## Interface

**Parameters**
- `NLANES`, default 4: bytes per word; data width is 8*NLANES.
- `NUNITS`, default 1: S-box units instantiated per direction.
  - Legal range: 1 ≤ NUNITS ≤ NLANES, and NUNITS must divide NLANES.
  - Elaboration error otherwise.
- `BEATS` (localparam), = NLANES/NUNITS: processing cycles per word.

**Ports**
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  input word valid.
- `ready_o`  out  1  engine can accept a word.
- `data_i`  in  8*NLANES  input word; byte k = bits [8k+7:8k].
- `inv_i`  in  1  0 = forward S-box, 1 = inverse S-box; sampled with `data_i`.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  downstream accepts the result.
- `data_o`  out  8*NLANES  result word, same byte ordering as `data_i`.

One clock; reset is asynchronous and active-low.

## Operation

**Tables**
- Forward: the AES S-box, identical to `sbox_case`.
- Inverse: the AES inverse S-box.

**FSM states:** IDLE, BUSY, DONE.

**IDLE**
- `ready_o`=1.
- On `valid_i`&&`ready_o`: latch `data_i` into the working register and `inv_i` into the mode flag; clear beat counter `cnt` to 0; go to BUSY.

**BUSY**
- `ready_o`=0 and `valid_o`=0.
- Each cycle, bytes NUNITS*cnt … NUNITS*cnt+NUNITS-1 are replaced in the working register by table(mode, byte).
- Processing order is lowest bytes first.
- `cnt` increments; on the beat with `cnt`=BEATS-1, `cnt` returns to 0 and the FSM goes to DONE.

**DONE**
- `valid_o`=1.
- `data_o` and the mode flag are held stable.
- On `ready_i`=1: go to IDLE.

**General rules**
- `data_o` is the working register at all times. Its content is meaningful only while `valid_o`=1.
- `data_i` and `inv_i` are ignored outside the accept cycle.
  - `inv_i` changes during BUSY/DONE have no effect.
  - `valid_i` asserted while `ready_o`=0 is not accepted; the upstream must hold it.
- `cnt` width is max(1, clog2(BEATS)). It never exceeds BEATS-1.
- NUNITS=NLANES gives BEATS=1: one BUSY cycle.

**Reset**
- Reset (any state, including mid-BUSY) forces: state IDLE, `cnt`=0, mode=0, working register=0.
- Outputs under reset: `valid_o`=0, `data_o`=0, `ready_o`=1.
- The in-flight word is discarded; no partial result is ever presented with `valid_o`=1.

## Timing

- **Accept at edge E0.** BUSY occupies cycles E0..E(BEATS), and `valid_o` rises after edge E(BEATS). Latency is BEATS cycles from accept edge to `valid_o`.
- **Result handshake.** It completes on the first edge with `valid_o`&&`ready_i`. `ready_o` rises on the following cycle.
- **Throughput.** With `ready_i` held at 1, one word every BEATS+2 cycles.
- **No combinational paths.**
  - `ready_o` and `valid_o` are decoded from the state register only.
  - There is no combinational path from `valid_i`/`ready_i` to any output.
  - `data_o` is registered.

## Test plan

1. **Forward, default parameters.** `data_i`=0x005301FF, `inv_i`=0, `ready_i`=1 → `valid_o` rises 4 cycles after accept with `data_o`=0x63ED7C16 for exactly one cycle; `ready_o` returns to 1 one cycle later.
2. **Inverse.** `data_i`=0x63ED7C16, `inv_i`=1 → `data_o`=0x005301FF. Toggling `inv_i` during BUSY leaves the result unchanged.
3. **Backpressure.** Hold `ready_i`=0 for 5 cycles in DONE while driving `valid_i`=1 with 0xFFFFFFFF → `valid_o`=1 and `data_o` stable for all 5 cycles, `ready_o`=0, new word not accepted. After `ready_i`=1, the new word is accepted in IDLE and returns 0x16161616.
4. **Reset mid-operation.** Assert `rst_ni`=0 asynchronously at `cnt`=2 → immediately `valid_o`=0, `data_o`=0, `ready_o`=1. After release, word 0x00000000 yields 0x63636363.
5. **Parameter sweep.** NLANES=4 with NUNITS ∈ {1,2,4}, plus NLANES=16 with NUNITS=4 → latencies 4/2/1/4.
   - All 256 byte values are checked in every lane against both tables.
   - The round trip inverse(forward(x))=x holds.
6. **Back-to-back stream.** 100 random words with random `inv_i`, `valid_i` and `ready_i` jitter → scoreboard matches in order. There is no loss or duplication, and the period is never shorter than BEATS+2.
